// File: rtl/mips_debug_pkg.sv
// Shared constants, state encoding and frame sizing for the Mips debug controller.
// Optional step counter enabled by defining MIPS_DEBUG_STEP_COUNT_EN.
package mips_debug_pkg;

    localparam logic [7:0] CMD_STEP     = 8'h53;
    localparam logic [7:0] CMD_RUN      = 8'h52;
    localparam logic [7:0] CMD_HALT     = 8'h48;
    localparam logic [7:0] CMD_DUMP     = 8'h44;
    localparam logic [7:0] CMD_CLEAR    = 8'h43;
    localparam logic [7:0] FRAME_HEADER = 8'hA5;

    localparam int STEP_COUNT_W = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        STEP    = 3'd1,
        RUN     = 3'd2,
        SETTLE  = 3'd3,
        CAPTURE = 3'd4,
        SEND    = 3'd5
    } state_t;

    // Header + data bytes + operation + function (+ step counter when enabled).
    function automatic int frame_len(input int nb_bits);
`ifdef MIPS_DEBUG_STEP_COUNT_EN
        return 1 + nb_bits / 8 + 2 + STEP_COUNT_W / 8;
`else
        return 1 + nb_bits / 8 + 2;
`endif
    endfunction

endpackage

// File: rtl/debug_frame_tx.sv
// Parallel-loaded frame buffer that streams its bytes MSB first over valid/ready.
// done pulses in the cycle the last byte is handed off.
module debug_frame_tx #(
    parameter int FRAME_LEN = 7
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   load,
    input  logic [FRAME_LEN*8-1:0] frame,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   done
);

    localparam int FRAME_W = FRAME_LEN * 8;
    localparam int IDX_W   = $clog2(FRAME_LEN + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    logic [FRAME_W-1:0] shift_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic               valid_reg;
    logic               handshake;

    assign handshake = valid_reg && tx_ready;
    assign done      = handshake && (idx_reg == LAST_IDX);
    assign tx_data   = shift_reg[FRAME_W-1 -: 8];
    assign tx_valid  = valid_reg;

    // The buffer only moves on a handshake, so data and valid hold during stalls.
    always_ff @(posedge clk) begin
        if (srst) begin
            shift_reg <= '0;
            idx_reg   <= '0;
            valid_reg <= 1'b0;
        end else if (load) begin
            shift_reg <= frame;
            idx_reg   <= '0;
            valid_reg <= 1'b1;
        end else if (handshake) begin
            shift_reg <= {shift_reg[FRAME_W-9:0], 8'h00};
            if (idx_reg == LAST_IDX) begin
                idx_reg   <= '0;
                valid_reg <= 1'b0;
            end else begin
                idx_reg <= idx_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mips_debug_ctrl.sv
// Host debug controller: decodes UART command bytes, steps/runs the Mips core and
// returns snapshot frames. Step counter in the frame when MIPS_DEBUG_STEP_COUNT_EN is defined.
module mips_debug_ctrl
    import mips_debug_pkg::*;
#(
    parameter int NB_BITS       = 32,
    parameter int NB_OP         = 6,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [7:0]         i_rx_data,
    input  logic               i_rx_valid,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_mips_valid,
    output logic               o_mips_continue,
    input  logic [NB_BITS-1:0] i_mips_data,
    input  logic [NB_OP-1:0]   i_mips_operation,
    input  logic [NB_OP-1:0]   i_mips_function,
    output logic               o_busy
);

    localparam int FRAME_LEN = frame_len(NB_BITS);
    localparam int SETTLE_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

    state_t                 state_reg, state_next;
    logic [SETTLE_W-1:0]    settle_cnt_reg, settle_cnt_next;
    logic                   mips_valid_reg, mips_continue_reg;
    logic                   frame_load, frame_done;
    logic                   cmd_clear;
    logic [FRAME_LEN*8-1:0] frame_word;

    always_comb begin
        state_next      = state_reg;
        settle_cnt_next = '0;
        frame_load      = 1'b0;
        cmd_clear       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (i_rx_valid) begin
                    case (i_rx_data)
                        CMD_STEP: state_next = STEP;
                        CMD_RUN:  state_next = RUN;
                        CMD_DUMP: state_next = SETTLE;
`ifdef MIPS_DEBUG_STEP_COUNT_EN
                        CMD_CLEAR: cmd_clear = 1'b1;
`endif
                        default: ;
                    endcase
                end
            end
            STEP:    state_next = SETTLE;
            RUN: begin
                if (i_rx_valid && (i_rx_data == CMD_HALT)) begin
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt_reg == SETTLE_LAST) begin
                    state_next = CAPTURE;
                end else begin
                    settle_cnt_next = settle_cnt_reg + 1'b1;
                end
            end
            CAPTURE: begin
                frame_load = 1'b1;
                state_next = SEND;
            end
            SEND: begin
                if (frame_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Core controls are registered from the next state so they align with STEP/RUN.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg         <= IDLE;
            settle_cnt_reg    <= '0;
            mips_valid_reg    <= 1'b0;
            mips_continue_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            settle_cnt_reg    <= settle_cnt_next;
            mips_valid_reg    <= (state_next == STEP);
            mips_continue_reg <= (state_next == RUN);
        end
    end

`ifdef MIPS_DEBUG_STEP_COUNT_EN
    logic [STEP_COUNT_W-1:0] step_cnt_reg;

    always_ff @(posedge i_clk) begin
        if (i_rst || cmd_clear) begin
            step_cnt_reg <= '0;
        end else if (mips_valid_reg || mips_continue_reg) begin
            step_cnt_reg <= step_cnt_reg + 1'b1;
        end
    end

    assign frame_word = {FRAME_HEADER, i_mips_data, 8'(i_mips_operation),
                         8'(i_mips_function), step_cnt_reg};
`else
    assign frame_word = {FRAME_HEADER, i_mips_data, 8'(i_mips_operation),
                         8'(i_mips_function)};
`endif

    debug_frame_tx #(
        .FRAME_LEN (FRAME_LEN)
    ) u_frame_tx (
        .clk      (i_clk),
        .srst     (i_rst),
        .load     (frame_load),
        .frame    (frame_word),
        .tx_data  (o_tx_data),
        .tx_valid (o_tx_valid),
        .tx_ready (i_tx_ready),
        .done     (frame_done)
    );

    assign o_mips_valid    = mips_valid_reg;
    assign o_mips_continue = mips_continue_reg;
    assign o_busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_mips_debug_ctrl.sv
// Self-checking bench for mips_debug_ctrl: directed and randomized commands against
// a frame/advance-count reference model. Honours MIPS_DEBUG_STEP_COUNT_EN.
module tb_mips_debug_ctrl;

    localparam int NB_BITS = 32;
    localparam int NB_OP   = 6;
    localparam logic [7:0] C_S = 8'h53, C_R = 8'h52, C_H = 8'h48, C_D = 8'h44, C_C = 8'h43;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [7:0]         rx_data = 8'h00;
    logic               rx_valid = 1'b0;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_ready = 1'b0;
    logic               mips_valid, mips_continue, busy;
    logic [NB_BITS-1:0] mips_data = '0;
    logic [NB_OP-1:0]   mips_op = '0;
    logic [NB_OP-1:0]   mips_fn = '0;

    int          total = 0;
    int          bad = 0;
    int          valid_cycles = 0;
    int          cont_cycles = 0;
    int          ready_mode = 0;
    bit          mon_hold = 1'b1;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;
    logic [7:0]  frame_q[$];
    logic [7:0]  exp_q[$];
    logic [31:0] model_count = 32'd0;

    always #5 clk = ~clk;

    mips_debug_ctrl #(
        .NB_BITS(NB_BITS), .NB_OP(NB_OP), .SETTLE_CYCLES(2)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
        .o_mips_valid(mips_valid), .o_mips_continue(mips_continue),
        .i_mips_data(mips_data), .i_mips_operation(mips_op),
        .i_mips_function(mips_fn), .o_busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Ready changes just after the rising edge so the negedge monitor sees the value used.
    always begin
        @(posedge clk);
        #2;
        case (ready_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ~tx_ready;
            2:       tx_ready = 1'($urandom_range(0, 1));
            default: tx_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (!mon_hold) begin
            if (mips_valid)    valid_cycles++;
            if (mips_continue) cont_cycles++;
            if (prev_stall) begin
                check("stall_valid", 32'(tx_valid), 32'd1);
                check("stall_data", 32'(tx_data), 32'(prev_data));
            end
            if (!busy && tx_valid) check("idle_tx_valid", 32'(tx_valid), 32'd0);
            if (tx_valid && tx_ready) frame_q.push_back(tx_data);
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < 5000), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_tx_valid(input string tag);
        int n = 0;
        while (!tx_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < 200), 32'd1);
    endtask

    task automatic new_snapshot();
        @(negedge clk);
        mips_data    = $urandom;
        mips_op      = NB_OP'($urandom);
        mips_fn      = NB_OP'($urandom);
        frame_q.delete();
        valid_cycles = 0;
        cont_cycles  = 0;
    endtask

    // Expected frame straight from the frame layout: header, data MSB first, op, func, [count].
    task automatic build_expected();
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int i = NB_BITS / 8 - 1; i >= 0; i--) exp_q.push_back(mips_data[i*8 +: 8]);
        exp_q.push_back({2'b00, mips_op});
        exp_q.push_back({2'b00, mips_fn});
`ifdef MIPS_DEBUG_STEP_COUNT_EN
        for (int i = 3; i >= 0; i--) exp_q.push_back(model_count[i*8 +: 8]);
`endif
    endtask

    task automatic check_frame(input string tag);
        build_expected();
        check({tag, "_len"}, 32'(frame_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < frame_q.size(); i++)
            check($sformatf("%s_b%0d", tag, i), 32'(frame_q[i]), 32'(exp_q[i]));
    endtask

    // One frame-producing command; gap is the extra idle cycles between 'R' and 'H'.
    task automatic do_cmd(input int idx, input logic [7:0] cmd, input int gap,
                          input int mode, input bit noise);
        int exp_valid, exp_cont;
        new_snapshot();
        ready_mode = mode;
        exp_valid  = (cmd == C_S) ? 1 : 0;
        exp_cont   = (cmd == C_R) ? gap + 2 : 0;
        send_byte(cmd);
        if (cmd == C_R) begin
            if (noise) begin
                send_byte(C_S);
                send_byte(C_D);
                send_byte(C_R);
                repeat (gap - 6) @(negedge clk);
            end else begin
                repeat (gap) @(negedge clk);
            end
            send_byte(C_H);
        end
        wait_idle("idle_timeout");
        model_count += 32'(exp_valid + exp_cont);
        check("valid_cycles", 32'(valid_cycles), 32'(exp_valid));
        check("cont_cycles", 32'(cont_cycles), 32'(exp_cont));
        check("busy_after", 32'(busy), 32'd0);
        check_frame("frame");
        $display("txn %0d cmd=%02h gap=%0d ready_mode=%0d bytes=%0d data=%08h",
                 idx, cmd, gap, mode, frame_q.size(), mips_data);
    endtask

    task automatic do_drop(input int idx, input logic [7:0] b);
        new_snapshot();
        ready_mode = 0;
        send_byte(b);
        repeat (8) @(negedge clk);
        check("drop_busy", 32'(busy), 32'd0);
        check("drop_frame", 32'(frame_q.size()), 32'd0);
        check("drop_advance", 32'(valid_cycles + cont_cycles), 32'd0);
        $display("txn %0d dropped byte=%02h", idx, b);
    endtask

    initial begin
        logic [7:0] rb;
        int         txn = 0;
        int         pick;

        // Reset with a command presented during reset.
        rst = 1'b1;
        @(negedge clk);
        rx_data = C_S; rx_valid = 1'b1;
        repeat (2) @(negedge clk);
        rx_valid = 1'b0;
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_outputs", 32'({mips_valid, mips_continue, busy}), 32'd0);
        rst = 1'b0;
        mon_hold = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_no_advance", 32'(valid_cycles + cont_cycles + frame_q.size()), 32'd0);

        // Directed step with fixed snapshot.
        new_snapshot();
        mips_data = 32'h12345678; mips_op = 6'h23; mips_fn = 6'h00;
        ready_mode = 0;
        send_byte(C_S);
        wait_idle("step_idle");
        model_count += 32'd1;
        check("step_valid", 32'(valid_cycles), 32'd1);
        check_frame("step_frame");
        check("step_b1", 32'(frame_q.size() > 1 ? frame_q[1] : 8'hxx), 32'h12);
        $display("txn %0d cmd=53 fixed frame bytes=%0d", txn++, frame_q.size());

        // Run for 20 cycles, run with ignored commands inside, dump with toggling ready.
        do_cmd(txn++, C_R, 18, 0, 1'b0);
        do_cmd(txn++, C_R, 10, 2, 1'b1);
        do_cmd(txn++, C_D, 0, 1, 1'b0);

        // Commands arriving while a frame is stalled in SEND are dropped.
        new_snapshot();
        ready_mode = 3;
        send_byte(C_D);
        wait_tx_valid("send_wait");
        send_byte(C_S);
        send_byte(C_D);
        ready_mode = 0;
        wait_idle("send_idle");
        check("send_drop_valid", 32'(valid_cycles), 32'd0);
        check_frame("send_drop_frame");
        repeat (10) @(negedge clk);
        check("send_drop_noextra", 32'(frame_q.size()), 32'(exp_q.size()));
        $display("txn %0d dump with commands during SEND bytes=%0d", txn++, frame_q.size());

        do_drop(txn++, 8'h7F);
        do_drop(txn++, C_H);
`ifndef MIPS_DEBUG_STEP_COUNT_EN
        do_drop(txn++, C_C);
`endif

        // Randomized commands and ready patterns.
        for (int i = 0; i < 10; i++) begin
            pick = $urandom_range(0, 3);
            if (pick == 3) begin
                do
                    rb = 8'($urandom);
                while (rb == C_S || rb == C_R || rb == C_D
`ifdef MIPS_DEBUG_STEP_COUNT_EN
                       || rb == C_C
`endif
                       );
                do_drop(txn++, rb);
            end else begin
                rb = (pick == 0) ? C_S : (pick == 1) ? C_R : C_D;
                do_cmd(txn++, rb, $urandom_range(0, 12), $urandom_range(0, 2), 1'b0);
            end
        end

        // Reset mid-frame aborts the frame and clears the counter.
        new_snapshot();
        ready_mode = 3;
        send_byte(C_D);
        wait_tx_valid("abort_wait");
        mon_hold = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check("abort_tx_valid", 32'(tx_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        model_count = 32'd0;
        ready_mode = 0;
        repeat (3) @(negedge clk);
        mon_hold = 1'b0;
        $display("txn %0d reset during SEND", txn++);

`ifdef MIPS_DEBUG_STEP_COUNT_EN
        for (int i = 0; i < 3; i++) do_cmd(txn++, C_S, 0, 0, 1'b0);
        do_cmd(txn++, C_D, 0, 0, 1'b0);
        check("count_three", 32'({frame_q[7], frame_q[8], frame_q[9], frame_q[10]}), 32'd3);
        do_drop(txn++, C_C);
        model_count = 32'd0;
        do_cmd(txn++, C_D, 0, 1, 1'b0);
`else
        for (int i = 0; i < 3; i++) do_cmd(txn++, C_S, 0, 0, 1'b0);
        do_cmd(txn++, C_D, 0, 0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_debug_ctrl.md
Name: mips_debug_ctrl

Overview:
- Host-side debug controller that drives the Mips core's execution-control inputs (i_valid, i_continue).
- Reads back the core's observation outputs (o_led, o_operation, o_function).
- Decodes single-byte host commands from an upstream byte receiver (UART RX).
- Returns snapshot frames through a valid/ready byte stream to a downstream transmitter (UART TX).
- Sits between the UART and inst_Mips in the board top level.

Parameters:
- NB_BITS, 32, width of the core data word observed on i_mips_data. Must be a multiple of 8.
- NB_OP, 6, width of the operation and function fields.
- SETTLE_CYCLES, 2, clock cycles waited after the core stops advancing before the snapshot is captured. Must be at least 1.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous, active-high reset.
- i_rx_data  in  8  host command byte.
- i_rx_valid  in  1  single-cycle strobe; i_rx_data is valid in that cycle.
- o_tx_data  out  8  response byte.
- o_tx_valid  out  1  response byte available.
- i_tx_ready  in  1  downstream accepts the byte when o_tx_valid && i_tx_ready.
- o_mips_valid  out  1  to Mips i_valid; the core advances one cycle for each cycle this is high.
- o_mips_continue  out  1  to Mips i_continue; the core free-runs while this is high.
- i_mips_data  in  NB_BITS  from Mips o_led.
- i_mips_operation  in  NB_OP  from Mips o_operation.
- i_mips_function  in  NB_OP  from Mips o_function.
- o_busy  out  1  high whenever state != IDLE.

Behaviour:
- Single clock domain: i_clk. Reset is synchronous and active-high on i_rst.
- Reset values: all outputs 0, state = IDLE.
- Reset asserted mid-frame aborts the frame; o_tx_valid is 0 on the cycle after i_rst is sampled high.

Commands (accepted only when i_rx_valid is high in IDLE or RUN):
- 0x53 'S' = step
- 0x52 'R' = run
- 0x48 'H' = halt
- 0x44 'D' = dump
- Any other code, or any byte arriving in another state, is silently dropped.

State machine:
- IDLE:
  - 'S' -> STEP.
  - 'R' -> RUN.
  - 'D' -> SETTLE.
  - 'H' ignored.
- STEP:
  - o_mips_valid = 1 for exactly one cycle.
  - Then -> SETTLE.
- RUN:
  - o_mips_continue = 1, registered and asserted from the cycle after the 'R' is accepted.
  - 'H' -> SETTLE; continue drops to 0 on the next cycle.
  - 'S', 'D', 'R' ignored.
- SETTLE:
  - Counts SETTLE_CYCLES cycles with o_mips_valid = 0 and o_mips_continue = 0.
  - Then -> CAPTURE.
- CAPTURE:
  - Registers i_mips_data, i_mips_operation and i_mips_function into the frame buffer in one cycle.
  - Then -> SEND.
- SEND:
  - Emits frame bytes in order. Frame:
    - 0xA5 header.
    - Data bytes MSB first (NB_BITS/8 bytes).
    - {2'b00, operation}.
    - {2'b00, function}.
  - Default frame length is 7 bytes.
  - o_tx_data and o_tx_valid are held stable while o_tx_valid && !i_tx_ready.
  - The byte index advances only on a handshake.
  - After the handshake on the last byte -> IDLE. o_busy falls the same cycle o_tx_valid falls.
  - i_tx_ready held low stalls SEND indefinitely; no timeout.

Boundary conditions:
- A command arriving in the same cycle as the last-byte handshake is dropped, because the state is still SEND.
- The core never advances outside STEP and RUN.

Optional Feature:
- Macro: MIPS_DEBUG_STEP_COUNT_EN.
- When defined:
  - Adds a 32-bit step counter, +1 on every cycle with o_mips_valid or o_mips_continue high. It wraps 0xFFFFFFFF -> 0.
  - The counter is appended MSB first to the frame after the function byte (frame = 11 bytes at default).
  - Command 0x43 'C' in IDLE clears the counter to 0 and sends no frame.
  - Reset clears the counter.
- When not defined:
  - No counter; 0x43 is an unknown code and is dropped.
  - Frame length is 7 bytes at default.

Decomposition:
- Shared package mips_debug_pkg holds:
  - Command codes: CMD_STEP, CMD_RUN, CMD_HALT, CMD_DUMP, CMD_CLEAR.
  - FRAME_HEADER = 8'hA5.
  - State encoding: IDLE, STEP, RUN, SETTLE, CAPTURE, SEND.
  - Frame-length function of NB_BITS and the feature macro.
- Sub-module debug_frame_tx:
  - Parallel-loaded frame buffer plus byte index.
  - Valid/ready output.
  - load/done handshake to the FSM.

Test Plan:
1. Reset with i_rst=1 for 3 cycles -> all outputs 0, o_busy=0. Any rx byte sent during reset is ignored.
2. Send 'S' with i_mips_data=0x12345678, op=0x23, func=0x00, i_tx_ready=1 -> o_mips_valid high exactly 1 cycle, then frame A5 12 34 56 78 23 00. o_busy returns to 0.
3. Send 'R', wait 20 cycles, send 'H' -> o_mips_continue high 20+ cycles, then 0. One frame is sent, and o_mips_valid stays 0 throughout.
4. Send 'D' with i_tx_ready toggling 1/0 every cycle -> 7 bytes with no duplicates or drops, o_tx_data stable during stalls, no core advance.
5. Send 'S' during SEND, 0x7F in IDLE, and 'H' in IDLE -> all dropped: no extra pulse and no extra frame.
6. With MIPS_DEBUG_STEP_COUNT_EN: 3x'S' then 'D' -> last 4 bytes 00 00 00 03. Then 'C' and 'D' -> 00 00 00 00.
